fp_rf_sequencer: RTL and testbench
==================================

FP_RF_SEQUENCER -- requirements
Module: fp_rf_sequencer

Interface
REQ-001 Parameter DEPTH, default 32, SHALL set the number of register-file words.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width, with DEPTH = 2**ADDR_W.
REQ-003 Parameter DATA_W, default 32, SHALL set the word width (IEEE-754 single).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-006 ld_en  in  1  SHALL be the load strobe; writes ld_data to ld_addr when accepted.
REQ-007 ld_addr  in  ADDR_W  SHALL be the load address.
REQ-008 ld_data  in  DATA_W  SHALL be the load data.
REQ-009 cmd_valid  in  1  SHALL indicate a valid add command.
REQ-010 cmd_ready  out  1  SHALL indicate the block can accept a command this cycle.
REQ-011 cmd_src_a, cmd_src_b, cmd_dst  in  ADDR_W each  SHALL be the operand and destination addresses.
REQ-012 add_a, add_b  out  DATA_W each  SHALL drive the operands of the external combinational fp adder.
REQ-013 add_sum  in  DATA_W  SHALL be the external adder result.
REQ-014 done  out  1  SHALL pulse for one cycle when a result is written back.
REQ-015 result  out  DATA_W  SHALL hold the last written-back sum.
REQ-016 rd_addr  in  ADDR_W; rd_data  out  DATA_W  SHALL be a registered readback port.
REQ-017 op_count  out  8  SHALL count completed operations.

Function
REQ-018 The FSM SHALL have states IDLE, RD_A, RD_B, ADD, WB.
REQ-019 cmd_ready SHALL equal (state==IDLE) AND NOT ld_en.
REQ-020 A load SHALL be performed only in IDLE; ld_en outside IDLE SHALL be ignored.
REQ-021 If ld_en and cmd_valid are both high in IDLE, the load SHALL execute and the command SHALL NOT be accepted.
REQ-022 The command SHALL be accepted on the edge where cmd_valid AND cmd_ready (cycle T); src_a, src_b and dst SHALL be latched.
REQ-023 IDLE->RD_A on acceptance; RD_A->RD_B->ADD->WB->IDLE unconditionally, one cycle each.
REQ-024 RD_A SHALL capture mem[src_a] into operand A; RD_B SHALL capture mem[src_b] into operand B.
REQ-025 add_a/add_b SHALL output operands A/B registers at all times; add_sum SHALL be sampled into result at the end of ADD.
REQ-026 WB SHALL write result to mem[dst], assert done for that cycle only, and increment op_count.
REQ-027 done SHALL be high in the cycle T+4 (four edges after acceptance); next command acceptable at T+5.
REQ-028 op_count SHALL wrap 255->0.
REQ-029 src_a==src_b, and dst equal to either source, SHALL be legal; sources SHALL be read before write-back.
REQ-030 rd_data SHALL update every edge to mem[rd_addr] in any state; a same-edge write to rd_addr SHALL return the old value.
REQ-031 Command inputs changing after acceptance SHALL not affect the operation in flight.

Reset
REQ-032 reset low SHALL immediately force state=IDLE, all memory words, operands, result, rd_data = 0, done=0, op_count=0.
REQ-033 reset asserted mid-operation SHALL abort it with no write-back and no done pulse.
REQ-034 After reset release, cmd_ready SHALL be 1 in the first cycle (absent ld_en).

Verification
REQ-035 Load mem[1]=0x3F800000, mem[2]=0x40000000; cmd (1,2,dst=3) -> done at T+4, result=mem[3]=0x40400000, op_count=1.
REQ-036 Simultaneous ld_en and cmd_valid in IDLE -> load written, cmd_ready=0, command accepted next cycle.
REQ-037 cmd (3,3,dst=3) with mem[3]=0x40400000 -> mem[3]=0x40C00000; readback of 3 during WB shows 0x40400000, next cycle 0x40C00000.
REQ-038 reset low during ADD -> state IDLE, mem[dst] and all words 0, no done, op_count 0.
REQ-039 256 back-to-back commands -> op_count returns to 0; done exactly 256 times, one every 5 cycles.
REQ-040 ld_en asserted during RD_B -> no memory change, readback unchanged.

Source files
------------

// File: rtl/fp_rf_sequencer.sv
// Register-file sequencer for an external combinational fp adder: loads words,
// then runs read-A / read-B / add / write-back for each accepted command.
module fp_rf_sequencer #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic [DATA_W-1:0] add_sum,
    output logic              done,
    output logic [DATA_W-1:0] result,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [7:0]        op_count
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, ADD, WB} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] src_a, src_b, dst;
    logic [DATA_W-1:0] op_a, op_b;
    logic              accept, ld_go;

    // A load in IDLE takes priority over a pending command.
    assign ld_go  = ld_en && (state == IDLE);
    assign accept = cmd_valid && cmd_ready;
    assign add_a  = op_a;
    assign add_b  = op_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !ld_en;
                if (cmd_valid && !ld_en) state_nxt = RD_A;
            end
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = ADD;
            ADD:     state_nxt = WB;
            WB: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_a    <= '0;
            src_b    <= '0;
            dst      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                src_a <= cmd_src_a;
                src_b <= cmd_src_b;
                dst   <= cmd_dst;
            end
            if (state == RD_A) op_a <= mem[src_a];
            if (state == RD_B) op_b <= mem[src_b];
            if (state == ADD)  result <= add_sum;
            if (state == WB)   op_count <= op_count + 8'd1;
        end
    end

    // Readback samples the pre-write contents, so a same-edge write shows next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
            if (ld_go)              mem[ld_addr] <= ld_data;
            else if (state == WB)   mem[dst]     <= result;
        end
    end

endmodule

// File: tb/tb_fp_rf_sequencer.sv
// Randomized bench for fp_rf_sequencer: transaction-level memory model plus a
// behavioural fp adder standing in for the external adder.
module tb_fp_rf_sequencer;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src_a, cmd_src_b, cmd_dst;
    logic [DW-1:0] add_a, add_b, add_sum;
    logic          done;
    logic [DW-1:0] result;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [7:0]    op_count;

    fp_rf_sequencer #(.DEPTH(32), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src_a(cmd_src_a),
        .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .done(done), .result(result), .rd_addr(rd_addr),
        .rd_data(rd_data), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Positive-only fp add, truncating; adequate as the external adder stand-in.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p, q;
        logic [23:0] mq;
        logic [24:0] s;
        int          e, d;
        if (x[30:0] == 31'd0) return y;
        if (y[30:0] == 31'd0) return x;
        if (x[30:23] >= y[30:23]) begin p = x; q = y; end
        else                      begin p = y; q = x; end
        e  = int'(p[30:23]);
        d  = e - int'(q[30:23]);
        mq = {1'b1, q[22:0]} >> d;
        s  = {2'b01, p[22:0]} + {1'b0, mq};
        if (s[24]) begin s = s >> 1; e++; end
        if (e > 254) e = 254;
        return {1'b0, 8'(e), s[22:0]};
    endfunction

    assign add_sum = fp_add(add_a, add_b);

    function automatic logic [31:0] rnd_fp();
        return {1'b0, 8'($urandom_range(140, 110)), 23'($urandom)};
    endfunction

    int          checks = 0, fails = 0, cyc_n = 0, done_cnt = 0;
    logic [31:0] mem_m [32];
    logic [7:0]  op_m = 8'd0;
    logic [31:0] exp_rd = 32'd0;
    bit          pend_we = 1'b0;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_rd(input logic [4:0] a);
        rd_addr = a;
        exp_rd  = mem_m[a];
    endtask

    // Advance one cycle: commit pending model writes at the edge, check readback.
    task automatic next_cycle();
        @(posedge clk);
        if (pend_we) mem_m[pend_addr] = pend_data;
        pend_we = 1'b0;
        @(negedge clk);
        cyc_n++;
        chk("rd_data", rd_data, exp_rd);
        set_rd(5'($urandom));
    endtask

    task automatic do_load(input logic [4:0] a, input logic [31:0] v);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        #1 chk("rdy_during_ld", {31'd0, cmd_ready}, 32'd0);
        pend_we = 1'b1; pend_addr = a; pend_data = v;
        next_cycle();
        ld_en = 1'b0;
    endtask

    task automatic do_cmd(input logic [4:0] a, b, d, input bit with_ld, inj, abort);
        logic [31:0] ex;
        cmd_valid = 1'b1; cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
        if (with_ld) begin
            ld_en = 1'b1; ld_addr = 5'($urandom); ld_data = rnd_fp();
            #1 chk("rdy_ld_and_cmd", {31'd0, cmd_ready}, 32'd0);
            pend_we = 1'b1; pend_addr = ld_addr; pend_data = ld_data;
            next_cycle();
            ld_en = 1'b0;
        end
        #1 chk("rdy_idle", {31'd0, cmd_ready}, 32'd1);
        ex = fp_add(mem_m[a], mem_m[b]);
        next_cycle();                                   // RD_A
        cmd_valid = 1'($urandom); cmd_src_a = 5'($urandom);
        cmd_src_b = 5'($urandom); cmd_dst = 5'($urandom);
        chk("done_rda", {31'd0, done}, 32'd0);
        next_cycle();                                   // RD_B
        chk("done_rdb", {31'd0, done}, 32'd0);
        if (inj) begin
            ld_en = 1'b1; ld_addr = 5'($urandom); ld_data = $urandom;
        end
        next_cycle();                                   // ADD
        ld_en = 1'b0;
        chk("done_add", {31'd0, done}, 32'd0);
        chk("add_a", add_a, mem_m[a]);
        chk("add_b", add_b, mem_m[b]);
        if (abort) begin
            cmd_valid = 1'b0;
            reset = 1'b0;
            #1;
            for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
            op_m = 8'd0; exp_rd = 32'd0; pend_we = 1'b0;
            chk("abort_done", {31'd0, done}, 32'd0);
            chk("abort_opcnt", {24'd0, op_count}, 32'd0);
            chk("abort_result", result, 32'd0);
            chk("abort_rd", rd_data, 32'd0);
            chk("abort_rdy", {31'd0, cmd_ready}, 32'd1);
            next_cycle();
            next_cycle();
            reset = 1'b1;
            #1 chk("rdy_after_rst", {31'd0, cmd_ready}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                set_rd(k[0] ? d : 5'($urandom));
                next_cycle();
                chk("no_done_after_abort", {31'd0, done}, 32'd0);
            end
            chk("opcnt_after_abort", {24'd0, op_count}, 32'd0);
            return;
        end
        next_cycle();                                   // WB
        cmd_valid = 1'b0;
        chk("done_wb", {31'd0, done}, 32'd1);
        chk("result", result, ex);
        set_rd(d);
        pend_we = 1'b1; pend_addr = d; pend_data = ex;
        next_cycle();                                   // back in IDLE
        op_m++;
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("op_count", {24'd0, op_count}, {24'd0, op_m});
        set_rd(d);
    endtask

    initial begin
        int cyc0, dc0;
        logic [7:0] op0;
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
        reset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        cmd_valid = 1'b0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; rd_addr = '0;
        #1;
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_opcnt", {24'd0, op_count}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("rdy_first", {31'd0, cmd_ready}, 32'd1);

        // 1.0 + 2.0 -> 3.0, then 3.0 + 3.0 -> 6.0 in place
        do_load(5'd1, 32'h3F800000);
        do_load(5'd2, 32'h40000000);
        do_cmd(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        chk("mem3_3p0", mem_m[3], 32'h40400000);
        do_cmd(5'd3, 5'd3, 5'd3, 1'b0, 1'b1, 1'b0);
        chk("mem3_6p0", mem_m[3], 32'h40C00000);
        do_cmd(5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(2, 0)) do_load(5'($urandom), rnd_fp());
            do_cmd(5'($urandom), 5'($urandom), 5'($urandom),
                   ($urandom % 4) == 0, ($urandom % 3) == 0, 1'b0);
        end

        // abort during ADD wipes everything
        do_load(5'd1, rnd_fp());
        do_load(5'd2, rnd_fp());
        do_cmd(5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) do_load(5'($urandom), rnd_fp());
        op0 = op_m; cyc0 = cyc_n; dc0 = done_cnt;
        for (int i = 0; i < 256; i++)
            do_cmd(5'($urandom), 5'($urandom), 5'($urandom), 1'b0, ($urandom % 4) == 0, 1'b0);
        chk("b2b_wrap", {24'd0, op_count}, {24'd0, op0});
        chk("b2b_cycles", 32'(cyc_n - cyc0), 32'd1280);
        chk("b2b_dones", 32'(done_cnt - dc0), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
